regfile_wb_arbiter: RTL and testbench

Writeback controller for the single write port of the 32x32 register file (A3/WD3/WE3).
- Arbitrates between the ALU writeback stream and the data-memory load writeback stream, using valid/ready handshakes.
- Keeps a scoreboard of registers with outstanding loads and flags read-after-write hazards to the decode/stall logic.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter_if.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle for the register-file writeback controller: ALU and load writeback handshakes,
// load-issue tracking, decode source/destination addresses, hazard, write port and forwarding.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;

    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_rd;

    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              hazard;

    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;

    logic              fwd1_valid;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_valid;
    logic [DATA_W-1:0] fwd2_data;

    // Pipeline side: produces writeback requests and decode addresses.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output ld_issue, ld_issue_rd,
        output rs1, rs2, rd,
        input  alu_ready, ld_ready, hazard,
        input  we3, a3, wd3,
        input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

    // Writeback controller side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  ld_issue, ld_issue_rd,
        input  rs1, rs2, rd,
        output alu_ready, ld_ready, hazard,
        output we3, a3, wd3,
        output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback controller for the single register-file write port: ALU/load arbitration with an
// ALU anti-starvation counter, load scoreboard for RAW hazards. Optional forwarding: RF_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [NREG-1:0] ONE_HOT    = NREG'(1);

    function automatic logic is_x0(input logic [ADDR_W-1:0] r);
        return (r == {ADDR_W{1'b0}});
    endfunction

    logic              alu_gnt_s;
    logic              ld_gnt_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] wr_rd_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [SW-1:0]     starve_nxt_s;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   clr_mask_s;
    logic [NREG-1:0]   pending_nxt_s;

    logic [SW-1:0]     starve_r;
    logic [NREG-1:0]   pending_r;
    logic              we3_r;
    logic [ADDR_W-1:0] a3_r;
    logic [DATA_W-1:0] wd3_r;

    // Grant: load wins contention unless the ALU has lost STARVE_MAX cycles in a row.
    always_comb begin
        alu_gnt_s = 1'b0;
        ld_gnt_s  = 1'b0;
        case ({bus.alu_valid, bus.ld_valid})
            2'b10: alu_gnt_s = 1'b1;
            2'b01: ld_gnt_s  = 1'b1;
            2'b11: begin
                if (starve_r == STARVE_LIM) begin
                    alu_gnt_s = 1'b1;
                end else begin
                    ld_gnt_s  = 1'b1;
                end
            end
            default: begin
                alu_gnt_s = 1'b0;
                ld_gnt_s  = 1'b0;
            end
        endcase
    end

    assign bus.alu_ready = alu_gnt_s;
    assign bus.ld_ready  = ld_gnt_s;

    // Write-data mux for whichever requester transfers this cycle.
    always_comb begin
        xfer_s    = alu_gnt_s | ld_gnt_s;
        wr_rd_s   = {ADDR_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (alu_gnt_s) begin
            wr_rd_s   = bus.alu_rd;
            wr_data_s = bus.alu_data;
        end else if (ld_gnt_s) begin
            wr_rd_s   = bus.ld_rd;
            wr_data_s = bus.ld_data;
        end else begin
            wr_rd_s   = {ADDR_W{1'b0}};
            wr_data_s = {DATA_W{1'b0}};
        end
    end

    // Starvation count: saturating while the ALU waits, cleared when it wins or goes idle.
    always_comb begin
        starve_nxt_s = {SW{1'b0}};
        if (bus.alu_valid && !alu_gnt_s) begin
            if (starve_r == STARVE_LIM) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + SW'(1);
            end
        end else begin
            starve_nxt_s = {SW{1'b0}};
        end
    end

    // Scoreboard update: a new issue to the same register overrides a completing writeback.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (bus.ld_issue && !is_x0(bus.ld_issue_rd)) begin
            set_mask_s = ONE_HOT << bus.ld_issue_rd;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (ld_gnt_s) begin
            clr_mask_s = ONE_HOT << bus.ld_rd;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
        pending_nxt_s[0] = 1'b0;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= {SW{1'b0}};
        end else begin
            starve_r <= starve_nxt_s;
        end
    end

    // Pending-load scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Registered write port; an accepted x0 write is swallowed and address/data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_r <= 1'b0;
            a3_r  <= {ADDR_W{1'b0}};
            wd3_r <= {DATA_W{1'b0}};
        end else if (xfer_s && !is_x0(wr_rd_s)) begin
            we3_r <= 1'b1;
            a3_r  <= wr_rd_s;
            wd3_r <= wr_data_s;
        end else begin
            we3_r <= 1'b0;
        end
    end

    assign bus.we3 = we3_r;
    assign bus.a3  = a3_r;
    assign bus.wd3 = wd3_r;

    // Destination is included so decode cannot re-issue a load to a still-pending register.
    assign bus.hazard = pending_r[bus.rs1] | pending_r[bus.rs2] | pending_r[bus.rd];

`ifdef RF_WB_FWD_EN
    // Bypass the value being committed this cycle; the array still holds the old one.
    assign bus.fwd1_valid = we3_r && (a3_r == bus.rs1) && !is_x0(bus.rs1);
    assign bus.fwd1_data  = wd3_r;
    assign bus.fwd2_valid = we3_r && (a3_r == bus.rs2) && !is_x0(bus.rs2);
    assign bus.fwd2_data  = wd3_r;
`else
    assign bus.fwd1_valid = 1'b0;
    assign bus.fwd1_data  = {DATA_W{1'b0}};
    assign bus.fwd2_valid = 1'b0;
    assign bus.fwd2_data  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a behavioural model of arbitration, scoreboard and write port.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 3;
`ifdef RF_WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [DATA_W-1:0] rf_tb [32];

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file array fed by the DUT write port.
    always @(posedge clk) begin
        if (bus.we3) rf_tb[bus.a3] <= bus.wd3;
    end

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
        bus.ld_issue = 1'b0;  bus.ld_issue_rd = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    endtask

    // Leaves time at one unit after a rising edge, with reset released.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.we3 !== 1'b0 || bus.a3 !== 5'd0 || bus.wd3 !== 32'd0) begin
            failures++; $display("FAIL reset_state got we3=%0b a3=%0d wd3=%h exp 0/0/0", bus.we3, bus.a3, bus.wd3); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hAAAA5555;
        @(posedge clk); #1;
        idle();
        checks++; if (bus.we3 !== 1'b1 || bus.a3 !== 5'd9) begin
            failures++; $display("FAIL reset_midwrite_setup got we3=%0b a3=%0d exp 1/9", bus.we3, bus.a3); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.we3 !== 1'b0 || bus.a3 !== 5'd0 || bus.wd3 !== 32'd0) begin
            failures++; $display("FAIL reset_async got we3=%0b a3=%0d wd3=%h exp 0/0/0", bus.we3, bus.a3, bus.wd3); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i); bus.rs2 = 5'(i); bus.rd = 5'(i);
            #1;
            checks++; if (bus.hazard !== 1'b0) begin
                failures++; $display("FAIL reset_hazard reg=%0d got %0b exp 0", i, bus.hazard); end
        end
        idle();
        @(posedge clk); #1;
        checks++; if (bus.we3 !== 1'b0) begin
            failures++; $display("FAIL reset_discard got we3=%0b exp 0", bus.we3); end
    endtask

    task automatic test_alu_only();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
            failures++; $display("FAIL alu_ready got alu=%0b ld=%0b exp 1/0", bus.alu_ready, bus.ld_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.we3 !== 1'b1 || bus.a3 !== 5'd5 || bus.wd3 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alu_write got we3=%0b a3=%0d wd3=%h exp 1/5/deadbeef", bus.we3, bus.a3, bus.wd3); end
        @(posedge clk); #1;
        checks++; if (rf_tb[5] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alu_rf_x5 got %h exp deadbeef", rf_tb[5]); end
        checks++; if (bus.we3 !== 1'b0 || bus.a3 !== 5'd5 || bus.wd3 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alu_hold got we3=%0b a3=%0d wd3=%h exp 0/5/deadbeef", bus.we3, bus.a3, bus.wd3); end
    endtask

    task automatic test_contention();
        bit exp_alu;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_alu = (i == 3);
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(100 + i);
            bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd2; bus.ld_data  = 32'(200 + i);
            #1;
            checks++; if (bus.alu_ready !== exp_alu || bus.ld_ready !== !exp_alu) begin
                failures++; $display("FAIL contention_grant cyc=%0d got alu=%0b ld=%0b exp alu=%0b", i, bus.alu_ready, bus.ld_ready, exp_alu); end
            @(posedge clk); #1;
            checks++; if (bus.we3 !== 1'b1 || bus.a3 !== (exp_alu ? 5'd1 : 5'd2) || bus.wd3 !== (exp_alu ? 32'(100 + i) : 32'(200 + i))) begin
                failures++; $display("FAIL contention_write cyc=%0d got a3=%0d wd3=%0d", i, bus.a3, bus.wd3); end
        end
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h00000123;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin
            failures++; $display("FAIL x0_ld_ready got %0b exp 1", bus.ld_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.we3 !== 1'b0) begin
            failures++; $display("FAIL x0_ld_we3 got %0b exp 0", bus.we3); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00000456;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin
            failures++; $display("FAIL x0_alu_ready got %0b exp 1", bus.alu_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.we3 !== 1'b0) begin
            failures++; $display("FAIL x0_alu_we3 got %0b exp 0", bus.we3); end
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd0;
        @(posedge clk); #1;
        idle();
        #1;
        checks++; if (bus.hazard !== 1'b0) begin
            failures++; $display("FAIL x0_issue_hazard got %0b exp 0", bus.hazard); end
        @(posedge clk); #1;
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
        @(posedge clk); #1;
        idle();
        bus.rs2 = 5'd7;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin
            failures++; $display("FAIL sb_set_rs2 got %0b exp 1", bus.hazard); end
        bus.rs2 = 5'd0; bus.rd = 5'd7;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin
            failures++; $display("FAIL sb_set_rd got %0b exp 1", bus.hazard); end
        bus.rd = 5'd6;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin
            failures++; $display("FAIL sb_other_reg got %0b exp 0", bus.hazard); end
        @(posedge clk); #1;
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h77;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin
            failures++; $display("FAIL sb_same_cycle_ready got %0b exp 1", bus.ld_ready); end
        @(posedge clk); #1;
        idle();
        bus.rs1 = 5'd7;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin
            failures++; $display("FAIL sb_set_wins got %0b exp 1", bus.hazard); end
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h78;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin
            failures++; $display("FAIL sb_clear got %0b exp 0", bus.hazard); end
        idle();
    endtask

    task automatic test_forward();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h12;
        @(posedge clk); #1;
        idle();
        bus.rs1 = 5'd3; bus.rs2 = 5'd3;
        #1;
        checks++; if (bus.fwd1_valid !== FWD_EN || bus.fwd1_data !== (FWD_EN ? 32'h12 : 32'h0)) begin
            failures++; $display("FAIL fwd1 got v=%0b d=%h exp v=%0b", bus.fwd1_valid, bus.fwd1_data, FWD_EN); end
        checks++; if (bus.fwd2_valid !== FWD_EN || bus.fwd2_data !== (FWD_EN ? 32'h12 : 32'h0)) begin
            failures++; $display("FAIL fwd2 got v=%0b d=%h exp v=%0b", bus.fwd2_valid, bus.fwd2_data, FWD_EN); end
        bus.rs1 = 5'd4;
        #1;
        checks++; if (bus.fwd1_valid !== 1'b0) begin
            failures++; $display("FAIL fwd1_miss got %0b exp 0", bus.fwd1_valid); end
        @(posedge clk); #1;
        bus.rs1 = 5'd3;
        #1;
        checks++; if (bus.fwd1_valid !== 1'b0) begin
            failures++; $display("FAIL fwd1_after_commit got %0b exp 0", bus.fwd1_valid); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0]       pend_m;
        int                starve_m;
        bit                we_m, known_m, g_alu, g_ld, exp_f1, exp_f2, exp_hz;
        logic [ADDR_W-1:0] a3_m;
        logic [DATA_W-1:0] wd3_m;
        do_reset();
        pend_m = '0; starve_m = 0; we_m = 1'b0; known_m = 1'b1; a3_m = '0; wd3_m = '0;
        for (int c = 0; c < 600; c++) begin
            bus.alu_valid   = ($urandom_range(0, 99) < 60);
            bus.alu_rd      = 5'($urandom_range(0, 7));
            bus.alu_data    = $urandom;
            bus.ld_valid    = ($urandom_range(0, 99) < 60);
            bus.ld_rd       = 5'($urandom_range(0, 7));
            bus.ld_data     = $urandom;
            bus.ld_issue    = ($urandom_range(0, 99) < 30);
            bus.ld_issue_rd = 5'($urandom_range(0, 7));
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            bus.rd  = 5'($urandom_range(0, 7));
            #1;
            g_alu  = bus.alu_valid && (!bus.ld_valid || starve_m == STARVE_MAX);
            g_ld   = bus.ld_valid && !g_alu;
            exp_hz = pend_m[bus.rs1] | pend_m[bus.rs2] | pend_m[bus.rd];
            exp_f1 = FWD_EN && we_m && a3_m == bus.rs1 && bus.rs1 != 5'd0;
            exp_f2 = FWD_EN && we_m && a3_m == bus.rs2 && bus.rs2 != 5'd0;
            checks++; if (bus.alu_ready !== g_alu || bus.ld_ready !== g_ld) begin
                failures++; $display("FAIL rnd_grant cyc=%0d got alu=%0b ld=%0b exp %0b/%0b", c, bus.alu_ready, bus.ld_ready, g_alu, g_ld); end
            checks++; if (bus.hazard !== exp_hz) begin
                failures++; $display("FAIL rnd_hazard cyc=%0d got %0b exp %0b", c, bus.hazard, exp_hz); end
            checks++; if (bus.fwd1_valid !== exp_f1 || bus.fwd2_valid !== exp_f2 || (exp_f1 && bus.fwd1_data !== wd3_m) || (exp_f2 && bus.fwd2_data !== wd3_m)) begin
                failures++; $display("FAIL rnd_fwd cyc=%0d got v1=%0b v2=%0b exp %0b/%0b", c, bus.fwd1_valid, bus.fwd2_valid, exp_f1, exp_f2); end
            // Model of the state after this edge.
            if (g_alu || g_ld) begin
                if ((g_alu ? bus.alu_rd : bus.ld_rd) != 5'd0) begin
                    we_m = 1'b1; known_m = 1'b1;
                    a3_m  = g_alu ? bus.alu_rd : bus.ld_rd;
                    wd3_m = g_alu ? bus.alu_data : bus.ld_data;
                end else begin
                    we_m = 1'b0; known_m = 1'b0;
                end
            end else begin
                we_m = 1'b0;
            end
            if (bus.alu_valid && !g_alu) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
            else starve_m = 0;
            if (g_ld) pend_m[bus.ld_rd] = 1'b0;
            if (bus.ld_issue && bus.ld_issue_rd != 5'd0) pend_m[bus.ld_issue_rd] = 1'b1;
            @(posedge clk); #1;
            checks++; if (bus.we3 !== we_m || (known_m && (bus.a3 !== a3_m || bus.wd3 !== wd3_m))) begin
                failures++; $display("FAIL rnd_wport cyc=%0d got we3=%0b a3=%0d wd3=%h exp %0b/%0d/%h", c, bus.we3, bus.a3, bus.wd3, we_m, a3_m, wd3_m); end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        idle();
        #2;
        test_reset();
        test_alu_only();
        test_contention();
        test_x0();
        test_scoreboard();
        test_forward();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
